// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the register file with busy scoreboard.
package rf_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int ADDR_DEPTH_DEF = 32;
    localparam int ZERO_IDX       = 0;

    // True when an index names a real, writable, trackable register:
    // inside the implemented depth and not the hard-wired zero register.
    function automatic logic rf_idx_ok(input int idx, input int depth, input logic zero_reg);
        logic ok;
        if (idx >= depth) begin
            ok = 1'b0;
        end else if (zero_reg && (idx == ZERO_IDX)) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one bit per register, set on issue and cleared on writeback,
// with an incrementally maintained count of busy registers.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int ADDR_DEPTH = ADDR_DEPTH_DEF,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we3_i,
    input  logic [ADDR_WIDTH-1:0] a3_i,
    input  logic                  we4_i,
    input  logic [ADDR_WIDTH-1:0] a4_i,
    input  logic                  issue_en_i,
    input  logic [ADDR_WIDTH-1:0] issue_rd_i,
    input  logic [ADDR_WIDTH-1:0] a1_i,
    input  logic [ADDR_WIDTH-1:0] a2_i,
    output logic                  busy1_o,
    output logic                  busy2_o,
    output logic [ADDR_WIDTH:0]   pend_cnt_o,
    output logic                  idle_o
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [ADDR_DEPTH-1:0] busy_q;
    logic [ADDR_DEPTH-1:0] busy_d;
    logic [ADDR_DEPTH-1:0] set_s;
    logic [ADDR_DEPTH-1:0] clr_s;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [CW-1:0]         inc_s;
    logic [CW-1:0]         dec_s;

    // Busy bit of one read address, masked when its producer writes back now.
    function automatic logic busy_lookup(
        input logic [ADDR_DEPTH-1:0] busy_vec,
        input logic [ADDR_WIDTH-1:0] a,
        input logic                  we3,
        input logic [ADDR_WIDTH-1:0] a3,
        input logic                  we4,
        input logic [ADDR_WIDTH-1:0] a4
    );
        logic b;
        logic fwd;
        b = 1'b0;
        for (int i = 0; i < ADDR_DEPTH; i++) begin
            if (a == ADDR_WIDTH'(i)) begin
                b = busy_vec[i];
            end else begin
                b = b;
            end
        end
        fwd = (we3 && (a3 == a)) || (we4 && (a4 == a));
        if (!rf_idx_ok(int'(a), ADDR_DEPTH, ZERO_REG != 0)) begin
            b = 1'b0;
        end else if ((BYPASS != 0) && fwd) begin
            b = 1'b0;
        end else begin
            b = b;
        end
        return b;
    endfunction

    // Next busy vector: a new issue beats a writeback to the same register;
    // the counter moves by the bits that actually change.
    always_comb begin
        busy_d = busy_q;
        set_s  = '0;
        clr_s  = '0;
        inc_s  = '0;
        dec_s  = '0;
        for (int i = 0; i < ADDR_DEPTH; i++) begin
            set_s[i] = issue_en_i && (issue_rd_i == ADDR_WIDTH'(i))
                       && rf_idx_ok(i, ADDR_DEPTH, ZERO_REG != 0);
            clr_s[i] = (we3_i && (a3_i == ADDR_WIDTH'(i))) || (we4_i && (a4_i == ADDR_WIDTH'(i)));
            if (set_s[i]) begin
                busy_d[i] = 1'b1;
            end else if (clr_s[i]) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
            inc_s = inc_s + {{(CW-1){1'b0}}, (set_s[i] & ~busy_q[i])};
            dec_s = dec_s + {{(CW-1){1'b0}}, (clr_s[i] & ~set_s[i] & busy_q[i])};
        end
        cnt_d = cnt_q + inc_s - dec_s;
    end

    // Busy vector and pending counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read-port busy flags and counter-derived status.
    always_comb begin
        busy1_o    = busy_lookup(busy_q, a1_i, we3_i, a3_i, we4_i, a4_i);
        busy2_o    = busy_lookup(busy_q, a2_i, we3_i, a3_i, we4_i, a4_i);
        pend_cnt_o = cnt_q;
        idle_o     = (cnt_q == {CW{1'b0}});
    end

endmodule

// File: rtl/rf_sb_regfile.sv
// 2-read/2-write register file with writeback bypass, optional zero register
// and an attached busy scoreboard for RAW stall detection in decode.
module rf_sb_regfile
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_DEPTH = ADDR_DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    input  logic                  WE3,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic [DATA_WIDTH-1:0] WD3,
    input  logic                  WE4,
    input  logic [ADDR_WIDTH-1:0] A4,
    input  logic [DATA_WIDTH-1:0] WD4,
    input  logic                  ISSUE_EN,
    input  logic [ADDR_WIDTH-1:0] ISSUE_RD,
    output logic                  BUSY1,
    output logic                  BUSY2,
    output logic [ADDR_WIDTH:0]   PEND_CNT,
    output logic                  IDLE
);

    logic [DATA_WIDTH-1:0] mem_q [ADDR_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [ADDR_DEPTH];
    logic [DATA_WIDTH-1:0] arr1_s;
    logic [DATA_WIDTH-1:0] arr2_s;
    logic                  ok3_s;
    logic                  ok4_s;

    // Write arbitration: the load port overrides the ALU port on a collision.
    always_comb begin
        ok3_s = rf_idx_ok(int'(A3), ADDR_DEPTH, ZERO_REG != 0);
        ok4_s = rf_idx_ok(int'(A4), ADDR_DEPTH, ZERO_REG != 0);
        for (int i = 0; i < ADDR_DEPTH; i++) begin
            if (WE4 && ok4_s && (A4 == ADDR_WIDTH'(i))) begin
                mem_d[i] = WD4;
            end else if (WE3 && ok3_s && (A3 == ADDR_WIDTH'(i))) begin
                mem_d[i] = WD3;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Register array storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ADDR_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ADDR_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Array lookup for both read ports.
    always_comb begin
        arr1_s = '0;
        arr2_s = '0;
        for (int i = 0; i < ADDR_DEPTH; i++) begin
            if (A1 == ADDR_WIDTH'(i)) begin
                arr1_s = mem_q[i];
            end else begin
                arr1_s = arr1_s;
            end
            if (A2 == ADDR_WIDTH'(i)) begin
                arr2_s = mem_q[i];
            end else begin
                arr2_s = arr2_s;
            end
        end
    end

    // Read mux: zero/invalid index first, then the load port, then the ALU port.
    always_comb begin
        if (rst || !rf_idx_ok(int'(A1), ADDR_DEPTH, ZERO_REG != 0)) begin
            RD1 = '0;
        end else if ((BYPASS != 0) && WE4 && (A4 == A1)) begin
            RD1 = WD4;
        end else if ((BYPASS != 0) && WE3 && (A3 == A1)) begin
            RD1 = WD3;
        end else begin
            RD1 = arr1_s;
        end
        if (rst || !rf_idx_ok(int'(A2), ADDR_DEPTH, ZERO_REG != 0)) begin
            RD2 = '0;
        end else if ((BYPASS != 0) && WE4 && (A4 == A2)) begin
            RD2 = WD4;
        end else if ((BYPASS != 0) && WE3 && (A3 == A2)) begin
            RD2 = WD3;
        end else begin
            RD2 = arr2_s;
        end
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_DEPTH (ADDR_DEPTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .we3_i      (WE3),
        .a3_i       (A3),
        .we4_i      (WE4),
        .a4_i       (A4),
        .issue_en_i (ISSUE_EN),
        .issue_rd_i (ISSUE_RD),
        .a1_i       (A1),
        .a2_i       (A2),
        .busy1_o    (BUSY1),
        .busy2_o    (BUSY2),
        .pend_cnt_o (PEND_CNT),
        .idle_o     (IDLE)
    );

endmodule

// File: tb/tb_rf_sb_regfile.sv
// Bench for rf_sb_regfile: a bypassing full-depth instance and a
// non-bypassing 24-entry instance share the same stimulus.
module tb_rf_sb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  a1, a2, a3, a4, issue_rd;
    logic [31:0] wd3, wd4;
    logic        we3, we4, issue_en;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        busy1_b, busy2_b, busy1_n, busy2_n, idle_b, idle_n;
    logic [5:0]  pend_b, pend_n;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: [0] bypassing depth 32, [1] non-bypassing depth 24.
    logic [31:0] m_mem  [2][32];
    bit          m_busy [2][32];
    int          m_depth [2] = '{32, 24};
    bit          m_byp   [2] = '{1'b1, 1'b0};

    rf_sb_regfile u_byp (
        .clk(clk), .rst(rst), .A1(a1), .A2(a2), .RD1(rd1_b), .RD2(rd2_b),
        .WE3(we3), .A3(a3), .WD3(wd3), .WE4(we4), .A4(a4), .WD4(wd4),
        .ISSUE_EN(issue_en), .ISSUE_RD(issue_rd),
        .BUSY1(busy1_b), .BUSY2(busy2_b), .PEND_CNT(pend_b), .IDLE(idle_b)
    );

    rf_sb_regfile #(.ADDR_DEPTH(24), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .A1(a1), .A2(a2), .RD1(rd1_n), .RD2(rd2_n),
        .WE3(we3), .A3(a3), .WD3(wd3), .WE4(we4), .A4(a4), .WD4(wd4),
        .ISSUE_EN(issue_en), .ISSUE_RD(issue_rd),
        .BUSY1(busy1_n), .BUSY2(busy2_n), .PEND_CNT(pend_n), .IDLE(idle_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit m_ok(int inst, int a);
        return (a < m_depth[inst]) && (a != 0);
    endfunction

    function automatic logic [31:0] m_rd(int inst, int a);
        if (!m_ok(inst, a)) return 32'h0;
        if (m_byp[inst] && we4 && int'(a4) == a) return wd4;
        if (m_byp[inst] && we3 && int'(a3) == a) return wd3;
        return m_mem[inst][a];
    endfunction

    function automatic bit m_bsy(int inst, int a);
        if (!m_ok(inst, a)) return 1'b0;
        if (m_byp[inst] && ((we3 && int'(a3) == a) || (we4 && int'(a4) == a))) return 1'b0;
        return m_busy[inst][a];
    endfunction

    function automatic int m_pend(int inst);
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_busy[inst][r]);
        return c;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++) begin
                m_mem[k][r]  = 32'h0;
                m_busy[k][r] = 1'b0;
            end
    endtask

    // Apply the effect of one clock edge with the current inputs.
    task automatic m_edge();
        for (int k = 0; k < 2; k++) begin
            if (we3 && m_ok(k, int'(a3))) m_mem[k][a3] = wd3;
            if (we4 && m_ok(k, int'(a4))) m_mem[k][a4] = wd4;
            if (we3 && m_ok(k, int'(a3))) m_busy[k][a3] = 1'b0;
            if (we4 && m_ok(k, int'(a4))) m_busy[k][a4] = 1'b0;
            if (issue_en && m_ok(k, int'(issue_rd))) m_busy[k][issue_rd] = 1'b1;
        end
    endtask

    task automatic idle_in();
        we3 = 1'b0; a3 = 5'd0; wd3 = 32'h0;
        we4 = 1'b0; a4 = 5'd0; wd4 = 32'h0;
        issue_en = 1'b0; issue_rd = 5'd0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_in();
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'h0000_1234; issue_en = 1'b1; issue_rd = 5'd6;
        step();
        idle_in();
        a1 = 5'd5; a2 = 5'd6;
        we3 = 1'b1; a3 = 5'd6; wd3 = 32'hCAFE_0006; issue_en = 1'b1; issue_rd = 5'd7;
        #1;
        n_chk++; if (pend_b !== 6'd1) $display("FAIL pre_reset_pend got %0d exp 1", pend_b); else n_pass++;
        n_chk++; if (rd1_b !== 32'h0000_1234) $display("FAIL pre_reset_rd1 got %h exp 00001234", rd1_b); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_chk++; if (rd1_b !== 32'h0 || rd2_b !== 32'h0) $display("FAIL reset_rd_b got %h/%h exp 0/0", rd1_b, rd2_b); else n_pass++;
        n_chk++; if (rd1_n !== 32'h0 || rd2_n !== 32'h0) $display("FAIL reset_rd_n got %h/%h exp 0/0", rd1_n, rd2_n); else n_pass++;
        n_chk++; if (pend_b !== 6'd0 || idle_b !== 1'b1) $display("FAIL reset_pend got %0d idle %b exp 0/1", pend_b, idle_b); else n_pass++;
        step();
        rst = 1'b0;
        idle_in();
        #1;
        n_chk++; if (rd1_b !== 32'h0 || rd2_b !== 32'h0) $display("FAIL post_reset_rd got %h/%h exp 0/0", rd1_b, rd2_b); else n_pass++;
        n_chk++; if (pend_b !== 6'd0 || pend_n !== 6'd0) $display("FAIL post_reset_pend got %0d/%0d exp 0/0", pend_b, pend_n); else n_pass++;
    endtask

    task automatic test_bypass();
        idle_in();
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'h0000_5555;
        step();
        idle_in();
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEAD_BEEF; a1 = 5'd5;
        #1;
        n_chk++; if (rd1_b !== 32'hDEAD_BEEF) $display("FAIL bypass_rd1 got %h exp deadbeef", rd1_b); else n_pass++;
        n_chk++; if (rd1_n !== 32'h0000_5555) $display("FAIL nobypass_old got %h exp 00005555", rd1_n); else n_pass++;
        step();
        idle_in();
        #1;
        n_chk++; if (rd1_n !== 32'hDEAD_BEEF) $display("FAIL nobypass_new got %h exp deadbeef", rd1_n); else n_pass++;
        n_chk++; if (rd1_b !== 32'hDEAD_BEEF) $display("FAIL bypass_after got %h exp deadbeef", rd1_b); else n_pass++;
    endtask

    task automatic test_dual_write();
        idle_in();
        we3 = 1'b1; a3 = 5'd7; wd3 = 32'h11; we4 = 1'b1; a4 = 5'd7; wd4 = 32'h22; a2 = 5'd7;
        #1;
        n_chk++; if (rd2_b !== 32'h22) $display("FAIL dual_bypass got %h exp 22", rd2_b); else n_pass++;
        n_chk++; if (rd2_n !== 32'h0) $display("FAIL dual_old got %h exp 0", rd2_n); else n_pass++;
        step();
        idle_in();
        #1;
        n_chk++; if (rd2_b !== 32'h22 || rd2_n !== 32'h22) $display("FAIL dual_next got %h/%h exp 22/22", rd2_b, rd2_n); else n_pass++;
    endtask

    task automatic test_zero_reg();
        idle_in();
        we4 = 1'b1; a4 = 5'd0; wd4 = 32'hFFFF_FFFF; issue_en = 1'b1; issue_rd = 5'd0; a1 = 5'd0;
        #1;
        n_chk++; if (rd1_b !== 32'h0 || busy1_b !== 1'b0) $display("FAIL zero_same got %h busy %b exp 0/0", rd1_b, busy1_b); else n_pass++;
        step();
        idle_in();
        #1;
        n_chk++; if (rd1_b !== 32'h0 || rd1_n !== 32'h0) $display("FAIL zero_next got %h/%h exp 0/0", rd1_b, rd1_n); else n_pass++;
        n_chk++; if (busy1_b !== 1'b0 || pend_b !== 6'd0 || idle_b !== 1'b1) $display("FAIL zero_busy got %b pend %0d idle %b exp 0/0/1", busy1_b, pend_b, idle_b); else n_pass++;
    endtask

    task automatic test_scoreboard();
        idle_in(); issue_en = 1'b1; issue_rd = 5'd3;
        step();
        idle_in(); issue_en = 1'b1; issue_rd = 5'd9;
        step();
        idle_in(); a1 = 5'd3;
        #1;
        n_chk++; if (pend_b !== 6'd2 || pend_n !== 6'd2) $display("FAIL sb_pend2 got %0d/%0d exp 2/2", pend_b, pend_n); else n_pass++;
        n_chk++; if (busy1_b !== 1'b1 || busy1_n !== 1'b1 || idle_b !== 1'b0) $display("FAIL sb_busy got %b/%b idle %b exp 1/1/0", busy1_b, busy1_n, idle_b); else n_pass++;
        we3 = 1'b1; a3 = 5'd3; wd3 = 32'h3333;
        #1;
        n_chk++; if (busy1_b !== 1'b0 || busy1_n !== 1'b1) $display("FAIL sb_fwd_busy got %b/%b exp 0/1", busy1_b, busy1_n); else n_pass++;
        step();
        idle_in(); a1 = 5'd3;
        #1;
        n_chk++; if (pend_b !== 6'd1 || pend_n !== 6'd1 || busy1_b !== 1'b0) $display("FAIL sb_clear got %0d/%0d busy %b exp 1/1/0", pend_b, pend_n, busy1_b); else n_pass++;
    endtask

    task automatic test_race();
        idle_in(); issue_en = 1'b1; issue_rd = 5'd4;
        step();
        idle_in();
        issue_en = 1'b1; issue_rd = 5'd4; we3 = 1'b1; a3 = 5'd4; wd3 = 32'h44;
        we4 = 1'b1; a4 = 5'd4; wd4 = 32'h45; a1 = 5'd4;
        #1;
        n_chk++; if (busy1_b !== 1'b0 || busy1_n !== 1'b1) $display("FAIL race_same got %b/%b exp 0/1", busy1_b, busy1_n); else n_pass++;
        step();
        idle_in(); a1 = 5'd4;
        #1;
        n_chk++; if (busy1_b !== 1'b1 || pend_b !== 6'd2 || pend_n !== 6'd2) $display("FAIL race_after got %b pend %0d/%0d exp 1/2/2", busy1_b, pend_b, pend_n); else n_pass++;
        we3 = 1'b1; a3 = 5'd9; wd3 = 32'h9; we4 = 1'b1; a4 = 5'd9; wd4 = 32'h90;
        step();
        idle_in();
        #1;
        n_chk++; if (pend_b !== 6'd1 || pend_n !== 6'd1) $display("FAIL dual_clear got %0d/%0d exp 1/1", pend_b, pend_n); else n_pass++;
    endtask

    task automatic test_out_of_range();
        idle_in();
        we3 = 1'b1; a3 = 5'd28; wd3 = 32'hAAAA_0028; issue_en = 1'b1; issue_rd = 5'd28;
        step();
        idle_in(); a1 = 5'd28;
        #1;
        n_chk++; if (rd1_n !== 32'h0 || busy1_n !== 1'b0 || pend_n !== 6'd1) $display("FAIL oor_small got %h busy %b pend %0d exp 0/0/1", rd1_n, busy1_n, pend_n); else n_pass++;
        n_chk++; if (rd1_b !== 32'hAAAA_0028 || busy1_b !== 1'b1 || pend_b !== 6'd2) $display("FAIL oor_full got %h busy %b pend %0d exp aaaa0028/1/2", rd1_b, busy1_b, pend_b); else n_pass++;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic test_random();
        idle_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_reset();
        for (int c = 0; c < 400; c++) begin
            a1 = rnd_addr(); a2 = rnd_addr();
            we3 = 1'($urandom_range(0, 1)); a3 = rnd_addr(); wd3 = $urandom();
            we4 = 1'($urandom_range(0, 2) == 0); a4 = rnd_addr(); wd4 = $urandom();
            issue_en = 1'($urandom_range(0, 1)); issue_rd = rnd_addr();
            #1;
            n_chk++; if (rd1_b !== m_rd(0, int'(a1)) || rd2_b !== m_rd(0, int'(a2)))
                $display("FAIL rnd_rd_b cyc %0d got %h/%h exp %h/%h", c, rd1_b, rd2_b, m_rd(0, int'(a1)), m_rd(0, int'(a2))); else n_pass++;
            n_chk++; if (rd1_n !== m_rd(1, int'(a1)) || rd2_n !== m_rd(1, int'(a2)))
                $display("FAIL rnd_rd_n cyc %0d got %h/%h exp %h/%h", c, rd1_n, rd2_n, m_rd(1, int'(a1)), m_rd(1, int'(a2))); else n_pass++;
            n_chk++; if (busy1_b !== m_bsy(0, int'(a1)) || busy2_b !== m_bsy(0, int'(a2)))
                $display("FAIL rnd_busy_b cyc %0d got %b/%b exp %b/%b", c, busy1_b, busy2_b, m_bsy(0, int'(a1)), m_bsy(0, int'(a2))); else n_pass++;
            n_chk++; if (busy1_n !== m_bsy(1, int'(a1)) || busy2_n !== m_bsy(1, int'(a2)))
                $display("FAIL rnd_busy_n cyc %0d got %b/%b exp %b/%b", c, busy1_n, busy2_n, m_bsy(1, int'(a1)), m_bsy(1, int'(a2))); else n_pass++;
            n_chk++; if (pend_b !== 6'(m_pend(0)) || idle_b !== (m_pend(0) == 0))
                $display("FAIL rnd_pend_b cyc %0d got %0d idle %b exp %0d", c, pend_b, idle_b, m_pend(0)); else n_pass++;
            n_chk++; if (pend_n !== 6'(m_pend(1)) || idle_n !== (m_pend(1) == 0))
                $display("FAIL rnd_pend_n cyc %0d got %0d idle %b exp %0d", c, pend_n, idle_n, m_pend(1)); else n_pass++;
            m_edge();
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        a1 = 5'd0; a2 = 5'd0;
        idle_in();
        step();
        step();
        rst = 1'b0;
        test_reset();
        test_bypass();
        test_dual_write();
        test_zero_reg();
        test_scoreboard();
        test_race();
        test_out_of_range();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
